// File: rtl/mem_access_unit.sv
// Memory-stage access unit: issues data-memory requests, stalls the pipeline
// until the access completes or times out, and registers the MEM/WB stage.
module mem_access_unit #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  WB_in,
   input  logic [2:0]  MEM_in,
   input  logic [31:0] ALU_in,
   input  logic [31:0] WD_in,
   input  logic [4:0]  WN_in,
   input  logic        zero_in,
   input  logic        Jal_in,
   output logic        dm_req,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   input  logic        dm_ack,
   input  logic [31:0] dm_rdata,
   output logic        stall,
   output logic        PCSrc,
   output logic [1:0]  WB_out,
   output logic [31:0] RD_out,
   output logic [31:0] ALU_out,
   output logic [4:0]  WN_out,
   output logic        Jal_out,
   output logic        err
);

   localparam int unsigned CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [31:0] TMO_DATA = 32'hDEADBEEF;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state, next_state;
   logic [CW-1:0] cnt;
   logic          memop, issue, done, tmo;

   assign memop = MEM_in[1] | MEM_in[0];
   assign PCSrc = MEM_in[2] & zero_in;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Next state, stall and completion decode; an ack beats a coincident timeout
   always_comb begin
      next_state = state;
      stall      = 1'b0;
      issue      = 1'b0;
      done       = 1'b0;
      tmo        = 1'b0;
      case (state)
         IDLE: begin
            if (memop) begin
               stall      = 1'b1;
               issue      = 1'b1;
               next_state = BUSY;
            end
         end
         BUSY: begin
            if (dm_ack) begin
               done       = 1'b1;
               next_state = IDLE;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
               done       = 1'b1;
               tmo        = 1'b1;
               next_state = IDLE;
            end else begin
               stall = 1'b1;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Request qualifiers, wait counter and sticky timeout flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dm_req   <= 1'b0;
         dm_we    <= 1'b0;
         dm_addr  <= '0;
         dm_wdata <= '0;
         cnt      <= '0;
         err      <= 1'b0;
      end else begin
         if (issue) begin
            dm_req   <= 1'b1;
            dm_we    <= MEM_in[0];
            dm_addr  <= ALU_in;
            dm_wdata <= WD_in;
            cnt      <= '0;
         end else if (state == BUSY) begin
            if (done) dm_req <= 1'b0;
            else      cnt    <= cnt + CW'(1);
         end
         if (tmo) err <= 1'b1;
      end
   end

   // MEM/WB register; a stalled cycle retires a bubble
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         WB_out  <= '0;
         RD_out  <= '0;
         ALU_out <= '0;
         WN_out  <= '0;
         Jal_out <= 1'b0;
      end else if (stall) begin
         WB_out  <= '0;
         Jal_out <= 1'b0;
      end else begin
         WB_out  <= WB_in;
         ALU_out <= ALU_in;
         WN_out  <= WN_in;
         Jal_out <= Jal_in;
         if (!done)       RD_out <= '0;
         else if (tmo)    RD_out <= TMO_DATA;
         else if (dm_we)  RD_out <= '0;
         else             RD_out <= dm_rdata;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against a per-instruction
// latency/result model.
module tb_mem_access_unit;

   localparam int unsigned TO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  WB_in;
   logic [2:0]  MEM_in;
   logic [31:0] ALU_in, WD_in;
   logic [4:0]  WN_in;
   logic        zero_in, Jal_in;
   logic        dm_req, dm_we;
   logic [31:0] dm_addr, dm_wdata;
   logic        dm_ack;
   logic [31:0] dm_rdata;
   logic        stall, PCSrc;
   logic [1:0]  WB_out;
   logic [31:0] RD_out, ALU_out;
   logic [4:0]  WN_out;
   logic        Jal_out, err;

   int   checks = 0;
   int   errors = 0;
   logic err_exp = 1'b0;

   mem_access_unit #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .WB_in(WB_in), .MEM_in(MEM_in), .ALU_in(ALU_in), .WD_in(WD_in),
      .WN_in(WN_in), .zero_in(zero_in), .Jal_in(Jal_in),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .stall(stall), .PCSrc(PCSrc),
      .WB_out(WB_out), .RD_out(RD_out), .ALU_out(ALU_out), .WN_out(WN_out),
      .Jal_out(Jal_out), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // One instruction through the MEM stage; ack_at is the BUSY cycle (0-based)
   // carrying dm_ack, anything >= TO means the memory never answers.
   task automatic run_op(input logic [2:0] mem, input logic zero, input int ack_at,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] rdata);
      logic [1:0]  wb;
      logic [4:0]  wn;
      logic        jal, memop, wr, tmo, fin, was_stall;
      logic [31:0] exp_rd;
      int          exp_stalls, nstall;

      wb    = 2'($urandom);
      wn    = 5'($urandom);
      jal   = 1'($urandom);
      memop = mem[1] | mem[0];
      wr    = mem[0];
      tmo   = memop && (ack_at >= int'(TO));
      exp_stalls = !memop ? 0 : (tmo ? int'(TO) : ack_at + 1);
      exp_rd     = !memop ? 32'h0 : tmo ? 32'hDEADBEEF : wr ? 32'h0 : rdata;

      fin    = 1'b0;
      nstall = 0;
      for (int k = 0; k < int'(TO) + 4 && !fin; k++) begin
         @(negedge clk);
         if (k == 0) begin
            WB_in = wb; MEM_in = mem; ALU_in = alu; WD_in = wd;
            WN_in = wn; zero_in = zero; Jal_in = jal;
            dm_ack   = 1'($urandom);
            dm_rdata = $urandom;
            check("idle_req", 32'(dm_req), 32'h0);
         end else begin
            dm_ack   = (k - 1 == ack_at);
            dm_rdata = dm_ack ? rdata : $urandom;
            check("busy_req", 32'(dm_req), 32'h1);
            check("busy_addr", dm_addr, alu);
            check("busy_we", 32'(dm_we), 32'(wr));
            check("busy_wdata", dm_wdata, wd);
         end
         #1;
         if (k == 0) check("pcsrc", 32'(PCSrc), 32'(mem[2] & zero));
         was_stall = stall;
         if (stall) nstall++;
         else       fin = 1'b1;
         @(posedge clk);
         #1;
         if (was_stall) begin
            check("bubble_wb", 32'(WB_out), 32'h0);
            check("bubble_jal", 32'(Jal_out), 32'h0);
         end
      end
      if (!fin) check("op_never_done", 32'h0, 32'h1);
      if (tmo) err_exp = 1'b1;
      check("stall_cycles", 32'(nstall), 32'(exp_stalls));
      check("wb_out", 32'(WB_out), 32'(wb));
      check("alu_out", ALU_out, alu);
      check("wn_out", 32'(WN_out), 32'(wn));
      check("jal_out", 32'(Jal_out), 32'(jal));
      check("rd_out", RD_out, exp_rd);
      check("err", 32'(err), 32'(err_exp));
      check("req_after", 32'(dm_req), 32'h0);
      dm_ack = 1'b0;
   endtask

   initial begin
      logic [2:0] ops [7];
      ops = '{3'b000, 3'b100, 3'b010, 3'b001, 3'b011, 3'b110, 3'b101};

      rst = 1'b1; dm_ack = 1'b0; dm_rdata = '0;
      WB_in = '0; MEM_in = '0; ALU_in = '0; WD_in = '0; WN_in = '0;
      zero_in = 1'b0; Jal_in = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req", 32'(dm_req), 32'h0);
      check("rst_addr", dm_addr, 32'h0);
      check("rst_wb", 32'(WB_out), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      rst = 1'b0;

      // Directed: load acked on 3rd BUSY cycle, store, branch, load then ALU
      run_op(3'b010, 1'b0, 2, 32'h40, 32'h0, 32'h1234);
      run_op(3'b001, 1'b0, 0, $urandom, 32'hCAFE, $urandom);
      run_op(3'b100, 1'b1, 0, $urandom, $urandom, $urandom);
      run_op(3'b010, 1'b0, 4, $urandom, $urandom, $urandom);
      run_op(3'b000, 1'b0, 0, $urandom, $urandom, $urandom);
      // Timeout, then err must stay set across later ops
      run_op(3'b010, 1'b1, int'(TO) + 5, $urandom, $urandom, $urandom);
      run_op(3'b000, 1'b0, 0, $urandom, $urandom, $urandom);
      run_op(3'b001, 1'b0, 1, $urandom, $urandom, $urandom);

      // Reset in the 2nd BUSY cycle of a load; ack after release is ignored
      @(negedge clk);
      WB_in = 2'b11; MEM_in = 3'b010; ALU_in = 32'h80; Jal_in = 1'b1; dm_ack = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_req", 32'(dm_req), 32'h0);
      check("mid_rst_we", 32'(dm_we), 32'h0);
      check("mid_rst_addr", dm_addr, 32'h0);
      check("mid_rst_wb", 32'(WB_out), 32'h0);
      check("mid_rst_jal", 32'(Jal_out), 32'h0);
      check("mid_rst_err", 32'(err), 32'h0);
      err_exp = 1'b0;
      MEM_in = '0; WB_in = '0; Jal_in = 1'b0;
      @(negedge clk);
      rst = 1'b0; dm_ack = 1'b1; dm_rdata = 32'h5555;
      #1;
      check("post_rst_stall", 32'(stall), 32'h0);
      @(posedge clk);
      #1;
      check("post_rst_req", 32'(dm_req), 32'h0);
      check("post_rst_rd", RD_out, 32'h0);
      check("post_rst_err", 32'(err), 32'h0);
      dm_ack = 1'b0;

      // Randomized mix
      for (int i = 0; i < 60; i++)
         run_op(ops[$urandom_range(0, 6)], 1'($urandom), int'($urandom_range(0, TO + 2)),
                $urandom, $urandom, $urandom);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high; ports named clk and rst.
REQ-002 SHALL have parameter TIMEOUT, default 16, max wait cycles for dm_ack before abort.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  async active-high reset.
REQ-005 SHALL have inputs from EX/MEM: WB_in 2 (writeback ctrl), MEM_in 3 ({Branch,MemRead,MemWrite}), ALU_in 32 (address/result), WD_in 32 (store data), WN_in 5 (dest reg), zero_in 1, Jal_in 1.
REQ-006 SHALL have port dm_req  output  1  data-memory request, registered.
REQ-007 SHALL have ports dm_we  output  1;  dm_addr  output  32;  dm_wdata  output  32  (request qualifiers, registered).
REQ-008 SHALL have ports dm_ack  input  1;  dm_rdata  input  32  (completion and read data).
REQ-009 SHALL have port stall  output  1  freezes PC, IF/ID, ID/EX, EX/MEM, combinational.
REQ-010 SHALL have port PCSrc  output  1  branch taken = MEM_in[2] & zero_in, combinational.
REQ-011 SHALL have MEM/WB outputs, registered: WB_out 2, RD_out 32 (load data), ALU_out 32, WN_out 5, Jal_out 1.
REQ-012 SHALL have port err  output  1  sticky timeout flag.

Function
REQ-013 SHALL implement FSM with states IDLE, BUSY.
REQ-014 SHALL define memop = MEM_in[1] | MEM_in[0]; MemWrite set takes priority (both set = write).
REQ-015 In IDLE with memop=1: stall=1, and next edge goes BUSY, latches dm_addr=ALU_in, dm_wdata=WD_in, dm_we=MEM_in[0], sets dm_req=1, clears wait counter.
REQ-016 In IDLE with memop=0: stall=0, state stays IDLE, dm_req=0.
REQ-017 In BUSY: dm_req, dm_addr, dm_wdata, dm_we held stable until completion.
REQ-018 In BUSY with dm_ack=0: stall=1; wait counter increments each cycle.
REQ-019 In BUSY with dm_ack=1: stall=0 in that cycle; next edge -> IDLE, dm_req=0, RD_out=dm_rdata for reads, RD_out=0 for writes.
REQ-020 In BUSY with counter = TIMEOUT-1 and no ack: the cycle acts as completion (stall=0); next edge -> IDLE, dm_req=0, RD_out=32'hDEADBEEF, err=1 (sticky until rst).
REQ-021 On each edge with stall=0, MEM/WB SHALL capture WB_in, ALU_in, WN_in, Jal_in (and RD_out per REQ-019/020; RD_out=0 for non-memory ops).
REQ-022 On each edge with stall=1, MEM/WB SHALL take a bubble: WB_out=0, Jal_out=0; other MEM/WB fields don't-care.
REQ-023 Minimum memory-op latency is 2 cycles (IDLE issue + BUSY ack); non-memory ops take 1 cycle, no stall.
REQ-024 dm_ack while in IDLE SHALL be ignored (no state, data or err change).
REQ-025 PCSrc is independent of stall and the FSM.

Reset
REQ-026 On rst high at any time, including mid-BUSY: state=IDLE, dm_req=0, dm_we=0, dm_addr=0, dm_wdata=0, counter=0, err=0, all MEM/WB outputs 0; an outstanding transaction is abandoned.
REQ-027 After rst deasserts, the first edge evaluates REQ-015/016 normally.

Verification
REQ-028 Load, MEM_in=3'b010, ALU_in=32'h40, dm_ack on 3rd BUSY cycle with dm_rdata=32'h1234 -> stall high 3 cycles, dm_addr=32'h40, dm_we=0, then RD_out=32'h1234, WB_out=WB_in, exactly one request.
REQ-029 Store, MEM_in=3'b001, WD_in=32'hCAFE, dm_ack 1st BUSY cycle -> dm_we=1, dm_wdata=32'hCAFE, stall high 1 cycle, RD_out=0.
REQ-030 Branch, MEM_in=3'b100, zero_in=1 -> PCSrc=1 same cycle, stall=0, dm_req never asserted.
REQ-031 Load, dm_ack never, TIMEOUT=16 -> 16 stalled cycles, RD_out=32'hDEADBEEF, err=1 and stays 1 across later ops.
REQ-032 rst asserted in 2nd BUSY cycle, then dm_ack after release -> all outputs 0 immediately, ack ignored, err=0.
REQ-033 Stalled load followed by ALU op -> one bubble per stall cycle (WB_out=0), then load and ALU op retire in order on consecutive cycles.
